multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM control unit for the multi-cycle MIPS datapath (shared memory, IR, A/B, ALUOut regs).
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and handshakes with memory via mem_ready.
//  Has a memory-timeout watchdog. Decodes RTYPE(ADD,SUB,SLT,JR), ADDI, SLTI, LW, SW, J, JAL, BEQ, BNE.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready; 0 = never time out
//  CNT_W        32  width of the performance counters
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  op_code      in   6      IR[31:26]
//  func         in   6      IR[5:0]
//  zero         in   1      ALU zero flag (combinational, current cycle)
//  mem_ready    in   1      memory completes the current access this cycle
//  pc_we        out  1      PC write enable
//  pc_src       out  2      0=ALU result, 1=ALUOut, 2=jump target, 3=reg A (JR)
//  ir_we        out  1      IR write enable
//  i_or_d       out  1      0=PC address, 1=ALUOut address
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  reg_write    out  1      register file write enable
//  reg_dst      out  2      0=rt, 1=rd, 2=$31
//  reg_src      out  2      1=MDR, 2=ALUOut, 3=PC
//  alu_src_a    out  1      0=PC, 1=A
//  alu_src_b    out  2      0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op       out  2      0=ADD, 1=SUB, 2=SLT
//  illegal      out  1      1-cycle pulse: undefined opcode or funct
//  bus_err      out  1      1-cycle pulse: memory timeout
//  instr_cnt    out  CNT_W  retired instructions
//  cycle_cnt    out  CNT_W  cycles since reset
// BEHAVIOUR
//  - Outputs decode only from the registered state, except pc_we in BR (uses zero) and the handshake
//    writes (use mem_ready). Every output not listed for a state is 0.
//  - rst: state=RST, wait_cnt=0, counters=0, all outputs 0. The cycle after rst falls, state=FETCH.
//  - FETCH: mem_read, i_or_d=0, a=0, b=1, op=ADD. On mem_ready: ir_we=1, pc_we=1, pc_src=0, go to DEC.
//  - DEC: a=0, b=3, op=ADD (branch target goes to ALUOut). Next state by opcode:
//    RTYPE -> JR if func=8, else EXR. ADDI/SLTI -> EXI. LW/SW -> MADR. BEQ/BNE -> BR.
//    J -> JMP. JAL -> JAL. Any other opcode -> FETCH with illegal=1.
//  - EXR: a=1, b=0, op from func (32->0, 34->1, 42->2) -> WBR.
//    Unknown func: illegal=1, go to FETCH, no write.
//  - WBR: reg_write, reg_dst=1, reg_src=2 -> FETCH.
//  - EXI: a=1, b=2, op=0 (ADDI) or 2 (SLTI) -> WBI.
//  - WBI: reg_write, reg_dst=0, reg_src=2 -> FETCH.
//  - MADR: a=1, b=2, op=ADD -> MRD (LW) or MWR (SW).
//  - MRD: mem_read, i_or_d=1; wait for mem_ready -> MWB.
//  - MWB: reg_write, reg_dst=0, reg_src=1 -> FETCH.
//  - MWR: mem_write, i_or_d=1; wait for mem_ready -> FETCH.
//  - BR: a=1, b=0, op=SUB, pc_src=1.
//    pc_we = zero (BEQ) or ~zero (BNE). The opcode bit is latched in DEC. -> FETCH.
//  - JMP: pc_we, pc_src=2 -> FETCH.
//  - JAL: pc_we, pc_src=2, reg_write, reg_dst=2, reg_src=3. PC already holds PC+4. -> FETCH.
//  - JR: pc_we, pc_src=3 -> FETCH.
//  - Wait states (FETCH/MRD/MWR): wait_cnt increments each cycle mem_ready=0 and clears on state exit.
//    If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT with mem_ready=0:
//    bus_err=1, go to FETCH, and no ir_we/pc_we/reg_write for that access.
//    mem_ready in that same cycle wins (normal completion).
//  - The FSM samples op_code/func only in DEC and EXR/EXI/BR (IR is stable after FETCH).
//  - Retire point: entering FETCH from any state except RST; a bus_err or illegal exit does not retire.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined:
//    cycle_cnt increments every cycle rst=0.
//    instr_cnt increments at each retire.
//    Both wrap modulo 2^CNT_W.
//  MC_CTRL_PERF_EN undefined: both ports remain and are tied to 0. No counter flops.
// STRUCTURE
//  Package mc_ctrl_pkg holds:
//    opcode and funct constants.
//    state enum (RST, FETCH, DEC, EXR, WBR, EXI, WBI, MADR, MRD, MWB, MWR, BR, JMP, JAL, JR; 4 bits).
//    alu_op, pc_src, reg_dst, reg_src and alu_src_b encodings.
//  Sub-module mc_ctrl_alu_dec: combinational func->{alu_op, valid}, used in EXR.
// TESTING
//  - ADD (op 0, func 32), mem_ready=1: FETCH,DEC,EXR,WBR. reg_write=1 and reg_dst=1 in cycle 4 only.
//  - LW with mem_ready held low 3 cycles in MRD: mem_read/i_or_d stay 1 for 4 cycles, then MWB with reg_src=1.
//  - BEQ with zero=1: pc_we=1, pc_src=1 in BR. BNE with zero=1: pc_we=0. Both return to FETCH.
//  - MEM_TIMEOUT=4, mem_ready=0 in FETCH: bus_err pulses at wait_cnt=4, ir_we and pc_we never asserted.
//  - Opcode 63: illegal pulse in DEC, then FETCH. R-type func 0: illegal in EXR, reg_write stays 0.
//  - rst asserted in MWR: all outputs 0 next cycle, then FETCH.
//    With MC_CTRL_PERF_EN: 5 one-cycle-memory ADDs give instr_cnt=5.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/funct
// constants, FSM state encoding and the datapath mux/ALU select encodings.
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DEC, S_EXR, S_WBR, S_EXI, S_WBI, S_MADR,
    S_MRD, S_MWB, S_MWR, S_BR, S_JMP, S_JAL, S_JR
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_SLT = 2'd2} alu_op_e;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_REG_A = 2'd3} pc_src_e;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2} reg_dst_e;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_MDR = 2'd1, SRC_ALUOUT = 2'd2, SRC_PC = 2'd3} reg_src_e;
  typedef enum logic [1:0] {SRCB_B = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH2 = 2'd3} alu_src_b_e;

  // States that hold a memory access open until mem_ready
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags
// functs the EXR state cannot execute.
module mc_ctrl_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [1:0] alu_op,
  output logic       valid
);

  // funct -> ALU op; unknown functs leave the op at ADD and drop valid
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b0;
    case (func)
      FN_ADD: begin alu_op = ALU_ADD; valid = 1'b1; end
      FN_SUB: begin alu_op = ALU_SUB; valid = 1'b1; end
      FN_SLT: begin alu_op = ALU_SLT; valid = 1'b1; end
      default: begin alu_op = ALU_ADD; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath, with a memory
// handshake watchdog. Optional performance counters are built when
// MC_CTRL_PERF_EN is defined; otherwise cycle_cnt/instr_cnt are tied to 0.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       reg_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int                WAIT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam bit                TMO_EN     = (MEM_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  // Set in DEC for BNE (invert zero in BR) and SW (MADR goes to MWR)
  logic              alt_sel_q, alt_sel_d;

  logic [1:0] exr_alu_op;
  logic       exr_valid;
  logic       timeout;

  mc_ctrl_alu_dec u_alu_dec (
    .func   (func),
    .alu_op (exr_alu_op),
    .valid  (exr_valid)
  );

  assign timeout = TMO_EN && is_wait_state(state_q) && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

  // Next-state and Moore output decode; mem_ready/zero only gate the handshake and branch writes
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    alt_sel_d  = alt_sel_q;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    ir_we      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    reg_src    = SRC_NONE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DEC;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_DEC: begin
        alu_src_b = SRCB_IMM_SH2;
        alt_sel_d = (op_code == OP_BNE) || (op_code == OP_SW);
        case (op_code)
          OP_RTYPE:        state_d = (func == FN_JR) ? S_JR : S_EXR;
          OP_ADDI, OP_SLTI: state_d = S_EXI;
          OP_LW, OP_SW:    state_d = S_MADR;
          OP_BEQ, OP_BNE:  state_d = S_BR;
          OP_J:            state_d = S_JMP;
          OP_JAL:          state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        alu_op    = exr_alu_op;
        if (exr_valid) begin
          state_d = S_WBR;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WBR: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
        reg_src   = SRC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op_code == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = S_WBI;
      end
      S_WBI: begin
        reg_write = 1'b1;
        reg_dst   = DST_RT;
        reg_src   = SRC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_MADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = alt_sel_q ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MWB;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_MWB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RT;
        reg_src   = SRC_MDR;
        state_d   = S_FETCH;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = alt_sel_q ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_we   = 1'b1;
        pc_src  = PC_JUMP;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_we     = 1'b1;
        pc_src    = PC_JUMP;
        reg_write = 1'b1;
        reg_dst   = DST_RA;
        reg_src   = SRC_PC;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_we   = 1'b1;
        pc_src  = PC_REG_A;
        state_d = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

  // State, watchdog and latched opcode-select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
      alt_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      alt_sel_q  <= alt_sel_d;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // An instruction retires when control returns to FETCH normally
  assign retire = (state_d == S_FETCH) && (state_q != S_RST) && (state_q != S_FETCH)
                  && !illegal && !bus_err;

  // Free-running cycle count and retired-instruction count, both wrapping
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = instr_cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Each driven cycle pushes the
// control word the instruction sequence must produce; a single compare
// process checks every cycle. Counters are checked when MC_CTRL_PERF_EN
// is defined and expected to be 0 otherwise.
module tb_multicycle_controller;

  localparam int TMO = 4;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op_code = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_we, ir_we, i_or_d, mem_read, mem_write, reg_write, alu_src_a, illegal, bus_err;
  logic [1:0]  pc_src, reg_dst, reg_src, alu_src_b, alu_op;
  logic [31:0] instr_cnt, cycle_cnt;

  multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .reg_src(reg_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .bus_err(bus_err), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, reg_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       illegal, bus_err;
  } ctl_t;

  typedef struct {
    ctl_t        ctl;
    int unsigned instr;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_m = 0;
  int unsigned retired = 0;
  logic [5:0]  cur_op = 6'd0;
  logic [5:0]  cur_fn = 6'd0;
  logic        cur_z = 1'b0;

  // Cycles elapsed since the last reset
  always @(posedge clk) cyc_m <= rst ? 0 : cyc_m + 1;

  // Control word in port order
  function automatic ctl_t w(input logic pcw, input logic [1:0] pcs, input logic irw, iod, mr, mwr, rw,
                             input logic [1:0] rd, rs, input logic a, input logic [1:0] b, op,
                             input logic ill, be);
    return {pcw, pcs, irw, iod, mr, mwr, rw, rd, rs, a, b, op, ill, be};
  endfunction

  function automatic ctl_t w_fetch(input logic rdy, input logic tmo);
    return w(rdy, 2'd0, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0, !rdy && tmo);
  endfunction

  function automatic ctl_t w_dec(input logic ill);
    return w(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 2'd0, ill, 1'b0);
  endfunction

  function automatic ctl_t w_wb(input logic [1:0] rd, input logic [1:0] rs);
    return w(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd, rs, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic ctl_t w_alu(input logic [1:0] b, input logic [1:0] op, input logic ill);
    return w(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, b, op, ill, 1'b0);
  endfunction

  function automatic ctl_t w_mem(input logic wr);
    return w(1'b0, 2'd0, 1'b0, 1'b1, !wr, wr, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic ctl_t w_pc(input logic pcw, input logic [1:0] pcs, input logic link);
    return w(pcw, pcs, 1'b0, 1'b0, 1'b0, 1'b0, link, link ? 2'd2 : 2'd0, link ? 2'd3 : 2'd0,
             1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  // Drive one cycle and record what the outputs must be during it
  task automatic cyc(input logic r, input logic rdy, input ctl_t c, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; mem_ready = rdy; zero = cur_z; op_code = cur_op; func = cur_fn;
    e.ctl = c; e.instr = retired; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // A cycle whose outputs ignore mem_ready
  task automatic step(input ctl_t c, input string tag);
    cyc(1'b0, 1'($urandom_range(0, 1)), c, tag);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, w_fetch(1'b0, i == TMO), "FETCH");
    cyc(1'b0, 1'b1, w_fetch(1'b1, 1'b0), "FETCH");
  endtask

  task automatic mem_access(input int waits, input logic wr);
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, w_mem(wr), wr ? "MWR" : "MRD");
    cyc(1'b0, 1'b1, w_mem(wr), wr ? "MWR" : "MRD");
  endtask

  // One reset cycle seen from state `cur`, then the RST state with all outputs low
  task automatic do_reset(input ctl_t cur);
    cyc(1'b1, 1'b0, cur, "RSTIN");
    retired = 0;
    cyc(1'b0, 1'b0, '0, "RST");
  endtask

  // Full instruction: expected words follow the per-opcode sequences
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw);
    logic [1:0] aop;
    logic       ok;
    cur_op = op; cur_fn = fn; cur_z = z;
    $display("instr op=%0d func=%0d zero=%0d fetch_wait=%0d mem_wait=%0d retired=%0d",
             op, fn, z, fw, mw, retired);
    fetch(fw);
    case (op)
      6'd0: begin
        step(w_dec(1'b0), "DEC");
        if (fn == 6'd8) begin
          step(w_pc(1'b1, 2'd3, 1'b0), "JR");
        end else begin
          ok = 1'b1;
          case (fn)
            6'd32:   aop = 2'd0;
            6'd34:   aop = 2'd1;
            6'd42:   aop = 2'd2;
            default: begin aop = 2'd0; ok = 1'b0; end
          endcase
          step(w_alu(2'd0, aop, !ok), "EXR");
          if (!ok) return;
          step(w_wb(2'd1, 2'd2), "WBR");
        end
      end
      6'd8, 6'd10: begin
        step(w_dec(1'b0), "DEC");
        step(w_alu(2'd2, (op == 6'd10) ? 2'd2 : 2'd0, 1'b0), "EXI");
        step(w_wb(2'd0, 2'd2), "WBI");
      end
      6'd35: begin
        step(w_dec(1'b0), "DEC");
        step(w_alu(2'd2, 2'd0, 1'b0), "MADR");
        mem_access(mw, 1'b0);
        step(w_wb(2'd0, 2'd1), "MWB");
      end
      6'd43: begin
        step(w_dec(1'b0), "DEC");
        step(w_alu(2'd2, 2'd0, 1'b0), "MADR");
        mem_access(mw, 1'b1);
      end
      6'd4, 6'd5: begin
        step(w_dec(1'b0), "DEC");
        step(w((op == 6'd4) ? z : !z, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
               1'b1, 2'd0, 2'd1, 1'b0, 1'b0), "BR");
      end
      6'd2: begin
        step(w_dec(1'b0), "DEC");
        step(w_pc(1'b1, 2'd2, 1'b0), "JMP");
      end
      6'd3: begin
        step(w_dec(1'b0), "DEC");
        step(w_pc(1'b1, 2'd2, 1'b1), "JAL");
      end
      default: begin
        step(w_dec(1'b1), "DEC");
        return;
      end
    endcase
    retired++;
  endtask

  // Compare process: every queued cycle is checked in the low clock phase
  initial begin
    exp_t e;
    ctl_t act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {pc_we, pc_src, ir_we, i_or_d, mem_read, mem_write, reg_write, reg_dst, reg_src,
               alu_src_a, alu_src_b, alu_op, illegal, bus_err};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl[%s] at %0t: got %05h, expected %05h", e.tag, $time, act, e.ctl);
        end
        checks++;
        if (cycle_cnt !== (PERF ? cyc_m : 32'd0)) begin
          errors++;
          $display("FAIL cycle_cnt[%s] at %0t: got %0d, expected %0d", e.tag, $time, cycle_cnt,
                   PERF ? cyc_m : 32'd0);
        end
        checks++;
        if (instr_cnt !== (PERF ? e.instr : 32'd0)) begin
          errors++;
          $display("FAIL instr_cnt[%s] at %0t: got %0d, expected %0d", e.tag, $time, instr_cnt,
                   PERF ? e.instr : 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    cyc(1'b1, 1'b0, '0, "RSTIN");
    #3 lit("reset_outputs_zero", 32'({pc_we, ir_we, mem_read, mem_write, reg_write, bus_err}), 32'd0);
    cyc(1'b0, 1'b0, '0, "RST");

    // Five single-cycle-memory ADDs, then reset while sitting in FETCH
    for (int i = 0; i < 5; i++) do_instr(6'd0, 6'd32, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, w_fetch(1'b0, 1'b0), "RSTIN");
    #3 lit("perf_instr_cnt_5", instr_cnt, PERF ? 32'd5 : 32'd0);
    lit("perf_cycle_cnt_21", cycle_cnt, PERF ? 32'd21 : 32'd0);
    retired = 0;
    cyc(1'b0, 1'b0, '0, "RST");

    // R-type, immediate, memory and jump flavours
    do_instr(6'd0, 6'd32, 1'b0, 2, 0);
    do_instr(6'd0, 6'd34, 1'b1, 0, 0);
    do_instr(6'd0, 6'd42, 1'b0, 1, 0);
    do_instr(6'd0, 6'd8, 1'b0, 0, 0);
    do_instr(6'd8, 6'd17, 1'b0, 0, 0);
    do_instr(6'd10, 6'd3, 1'b1, 0, 0);
    do_instr(6'd35, 6'd0, 1'b0, 0, 3);
    do_instr(6'd43, 6'd5, 1'b0, 1, 2);
    do_instr(6'd43, 6'd0, 1'b1, 0, 0);

    // Branches: BEQ/BNE with both zero values
    do_instr(6'd4, 6'd0, 1'b1, 0, 0);
    #3 lit("beq_taken_pc_we", 32'(pc_we), 32'd1);
    lit("beq_taken_pc_src", 32'(pc_src), 32'd1);
    do_instr(6'd5, 6'd0, 1'b1, 0, 0);
    #3 lit("bne_zero1_pc_we", 32'(pc_we), 32'd0);
    do_instr(6'd4, 6'd0, 1'b0, 0, 0);
    do_instr(6'd5, 6'd0, 1'b0, 0, 0);
    #3 lit("bne_zero0_pc_we", 32'(pc_we), 32'd1);
    do_instr(6'd2, 6'd0, 1'b0, 0, 0);
    do_instr(6'd3, 6'd0, 1'b0, 0, 0);

    // Watchdog: ready on the limit cycle wins; counter clears between accesses
    do_instr(6'd0, 6'd32, 1'b0, TMO, 0);
    do_instr(6'd0, 6'd34, 1'b0, 3, 0);
    do_instr(6'd0, 6'd42, 1'b0, 3, 0);
    cur_op = 6'd0; cur_fn = 6'd32;
    $display("instr fetch timeout, mem_ready held low");
    for (int i = 0; i <= TMO; i++) cyc(1'b0, 1'b0, w_fetch(1'b0, i == TMO), "FETCH_TMO");
    #3 lit("timeout_bus_err", 32'(bus_err), 32'd1);
    lit("timeout_no_ir_we", 32'({ir_we, pc_we}), 32'd0);

    // Illegal opcode and illegal funct
    do_instr(6'd63, 6'd0, 1'b0, 0, 0);
    #3 lit("illegal_opcode", 32'(illegal), 32'd1);
    do_instr(6'd0, 6'd0, 1'b0, 0, 0);
    #3 lit("illegal_funct", 32'(illegal), 32'd1);
    lit("illegal_funct_no_write", 32'(reg_write), 32'd0);
    do_instr(6'd0, 6'd32, 1'b0, 0, 0);

    // Reset arriving while a store waits in MWR
    cur_op = 6'd43; cur_fn = 6'd0; cur_z = 1'b0;
    $display("instr SW interrupted by reset in MWR");
    fetch(0);
    step(w_dec(1'b0), "DEC");
    step(w_alu(2'd2, 2'd0, 1'b0), "MADR");
    cyc(1'b0, 1'b0, w_mem(1'b1), "MWR");
    do_reset(w_mem(1'b1));
    #3 lit("rst_in_mwr_outputs_zero", 32'({pc_we, pc_src, ir_we, i_or_d, mem_read, mem_write, reg_write,
                                           reg_dst, reg_src, alu_src_a, alu_src_b, alu_op, illegal,
                                           bus_err}), 32'd0);
    do_instr(6'd0, 6'd32, 1'b0, 0, 0);
    do_instr(6'd35, 6'd0, 1'b0, 1, 1);

    repeat (2) @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
